// File: rtl/shift_rx_pkg.sv
// Shared constants and helpers for the serial shift-stream receiver.
package shift_rx_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic CLR_ACTIVE  = 1'b0;

  // bit_cnt must hold 0..WIDTH+1 (WIDTH+1 marks an overrun)
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/shift_rx_sync_edge.sv
// Two-flop synchronizer plus a history flop, giving rise/fall pulses on the synced line.
// Latency: 2 clk to q, rise/fall valid combinationally after that; no backpressure.
module sync_edge
  import shift_rx_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign prev = prev_q;
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/shift_rx.sv
// Rebuilds the parallel word from the oversampled {sclk, sdo, pen, clr} stream.
// Latency: 3 clk from pen rise at the pin to pdata/valid; no backpressure, frames are never stalled.
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdo,
  input  logic             pen,
  input  logic             clr,
  output logic [WIDTH-1:0] pdata,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);

  logic sclk_q, sclk_prev, sclk_rise, sclk_fall;
  logic sdo_q, sdo_prev, sdo_rise, sdo_fall;
  logic pen_q, pen_prev, pen_rise, pen_fall;
  logic clr_q, clr_prev, clr_rise, clr_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_q), .prev(sclk_prev), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sync_sdo (
    .clk(clk), .rst(rst), .d(sdo),
    .q(sdo_q), .prev(sdo_prev), .rise(sdo_rise), .fall(sdo_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sync_pen (
    .clk(clk), .rst(rst), .d(pen),
    .q(pen_q), .prev(pen_prev), .rise(pen_rise), .fall(pen_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_clr (
    .clk(clk), .rst(rst), .d(clr),
    .q(clr_q), .prev(clr_prev), .rise(clr_rise), .fall(clr_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, sclk_prev, sclk_fall, sdo_prev, sdo_rise, sdo_fall,
                         pen_q, pen_fall, clr_prev, clr_rise, clr_fall};

  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;

  // pen as seen on the previous synced cycle gates the shift, so an sclk rise
  // coinciding with a pen rise still lands before the latch sees shift_nxt
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = bit_cnt;
    if (sclk_rise && !pen_prev) begin
      if (MSB_FIRST) begin
        shift_nxt = {shift_q[WIDTH-2:0], sdo_q};
      end else begin
        shift_nxt = {sdo_q, shift_q[WIDTH-1:1]};
      end
      if (bit_cnt != CNT_MAX) begin
        cnt_nxt = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      pdata     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (clr_q == CLR_ACTIVE) begin
        shift_q <= '0;
        bit_cnt <= '0;
        pdata   <= '0;
        busy    <= 1'b0;
      end else begin
        shift_q <= shift_nxt;
        if (pen_rise) begin
          if (cnt_nxt == CNT_FULL) begin
            pdata <= shift_nxt;
            valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          bit_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          bit_cnt <= cnt_nxt;
          busy    <= (cnt_nxt != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rx.sv
// Directed bench for shift_rx: one MSB-first and one LSB-first receiver on a shared stream.
module tb_shift_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        sdo = 1'b0;
  logic        pen = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] pdata, l_pdata;
  logic        valid, frame_err, busy;
  logic        l_valid, l_frame_err, l_busy;

  int checks = 0;
  int errors = 0;

  // observations from the last pen pulse
  int v_cyc, v_cnt, e_cnt, lv_cnt, le_cnt;

  always #5 clk = ~clk;

  shift_rx #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
    .pdata(pdata), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  shift_rx #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
    .pdata(l_pdata), .valid(l_valid), .frame_err(l_frame_err), .busy(l_busy)
  );

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // one bit at clk/8: 4 clk low with data set up, 4 clk high
  task automatic send_bit(input logic b);
    @(negedge clk);
    sclk = 1'b0;
    sdo  = b;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // raise pen between edges and record pulses over a bounded window
  task automatic pulse_pen();
    v_cyc = 0; v_cnt = 0; e_cnt = 0; lv_cnt = 0; le_cnt = 0;
    wait_clk(4);
    pen = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (v_cnt == 0) v_cyc = c;
        v_cnt++;
      end
      if (frame_err) e_cnt++;
      if (l_valid) lv_cnt++;
      if (l_frame_err) le_cnt++;
    end
    @(negedge clk);
    pen = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pdata !== 16'h0000) begin errors++; $display("FAIL reset_pdata got %h want 0000", pdata); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    wait_clk(3);
    rst = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_normal_frame();
    send_bits(32'h0000_A5C3, 16);
    pulse_pen();
    checks++; if (v_cnt !== 1) begin errors++; $display("FAIL normal_valid_count got %0d want 1", v_cnt); end
    checks++; if (v_cyc !== 3) begin errors++; $display("FAIL normal_latency got %0d want 3", v_cyc); end
    checks++; if (pdata !== 16'hA5C3) begin errors++; $display("FAIL normal_pdata got %h want a5c3", pdata); end
    checks++; if (e_cnt !== 0) begin errors++; $display("FAIL normal_err got %0d want 0", e_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy got %b want 0", busy); end
  endtask

  task automatic test_lsb_first();
    checks++; if (l_pdata !== 16'hC3A5) begin errors++; $display("FAIL lsb_pdata got %h want c3a5", l_pdata); end
    checks++; if (lv_cnt !== 1) begin errors++; $display("FAIL lsb_valid_count got %0d want 1", lv_cnt); end
  endtask

  task automatic test_short_frame();
    send_bits(32'h0000_7FFF, 15);
    pulse_pen();
    checks++; if (e_cnt !== 1) begin errors++; $display("FAIL short_err got %0d want 1", e_cnt); end
    checks++; if (v_cnt !== 0) begin errors++; $display("FAIL short_valid got %0d want 0", v_cnt); end
    checks++; if (pdata !== 16'hA5C3) begin errors++; $display("FAIL short_pdata got %h want a5c3", pdata); end
    send_bits(32'h0000_0001, 16);
    pulse_pen();
    checks++; if (pdata !== 16'h0001) begin errors++; $display("FAIL after_short_pdata got %h want 0001", pdata); end
    checks++; if (v_cnt !== 1) begin errors++; $display("FAIL after_short_valid got %0d want 1", v_cnt); end
  endtask

  task automatic test_overrun();
    send_bits(32'h0003_1234, 18);
    pulse_pen();
    checks++; if (e_cnt !== 1) begin errors++; $display("FAIL overrun_err got %0d want 1", e_cnt); end
    checks++; if (pdata !== 16'h0001) begin errors++; $display("FAIL overrun_pdata got %h want 0001", pdata); end
  endtask

  task automatic test_clear();
    send_bits(32'h0000_00AA, 8);
    wait_clk(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before got %b want 1", busy); end
    clr = 1'b0;
    wait_clk(4);
    clr = 1'b1;
    wait_clk(4);
    checks++; if (pdata !== 16'h0000) begin errors++; $display("FAIL clear_pdata got %h want 0000", pdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", busy); end
    send_bits(32'h0000_FFFF, 16);
    pulse_pen();
    checks++; if (pdata !== 16'hFFFF) begin errors++; $display("FAIL clear_next_pdata got %h want ffff", pdata); end
  endtask

  task automatic test_async_reset();
    send_bits(32'h0000_0155, 10);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pdata !== 16'h0000) begin errors++; $display("FAIL areset_pdata got %h want 0000", pdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL areset_err got %b want 0", frame_err); end
    wait_clk(3);
    rst = 1'b1;
    wait_clk(4);
    send_bits(32'h0000_8001, 16);
    pulse_pen();
    checks++; if (pdata !== 16'h8001) begin errors++; $display("FAIL areset_next_pdata got %h want 8001", pdata); end
    checks++; if (v_cnt !== 1) begin errors++; $display("FAIL areset_next_valid got %0d want 1", v_cnt); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_lsb_first();
    test_short_frame();
    test_overrun();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
